// File: rtl/rf_writeback_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rf_writeback_scheduler                                       |
// | Description : Shares the single register-file write port between the       |
// |               in-order pipeline (source 0) and the multi-cycle unit         |
// |               (source 1). Tracks registers awaiting a source-1 result in a  |
// |               32-entry scoreboard and stalls dependent issue.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rf_writeback_scheduler #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rs1_i,
  input  logic [4:0]        issue_rs2_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              issue_long_i,
  output logic              issue_ready_o,
  input  logic              wb0_valid_i,
  input  logic [4:0]        wb0_addr_i,
  input  logic [DATA_W-1:0] wb0_data_i,
  output logic              wb0_ready_o,
  input  logic              wb1_valid_i,
  input  logic [4:0]        wb1_addr_i,
  input  logic [DATA_W-1:0] wb1_data_i,
  output logic              wb1_ready_o,
  output logic              rf_write_o,
  output logic [4:0]        rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic [31:0]       busy_o
);

  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);
  localparam logic [2:0] c_starve_max   = 3'd7;

  logic [31:0]       r_busy;
  logic [2:0]        r_starve_cnt;
  logic              r_last_src1;
  logic              r_rf_write;
  logic [4:0]        r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic              w_src1_priority;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_hazard;
  logic              w_issue_set;
  logic              w_commit_clear;
  logic [31:0]       w_busy_next;

  // Hazard detection: any operand or destination still waiting on source 1.
  // Bit 0 is masked so x0 can never stall issue.
  always_comb begin
    w_hazard = 1'b0;
    if (issue_rs1_i != 5'd0) w_hazard = w_hazard | r_busy[issue_rs1_i];
    if (issue_rs2_i != 5'd0) w_hazard = w_hazard | r_busy[issue_rs2_i];
    if (issue_rd_i  != 5'd0) w_hazard = w_hazard | r_busy[issue_rd_i];
  end

  assign issue_ready_o = !w_hazard;

  // Write-port arbitration: source 0 wins unless source 1 has been starved
  // long enough, in which case the priority flips for one grant.
  always_comb begin
    w_src1_priority = (r_starve_cnt == c_starve_limit);
    if (w_src1_priority) begin
      w_grant1 = wb1_valid_i;
      w_grant0 = wb0_valid_i & !wb1_valid_i;
    end else begin
      w_grant0 = wb0_valid_i;
      w_grant1 = wb1_valid_i & !wb0_valid_i;
    end
  end

  assign wb0_ready_o = w_grant0;
  assign wb1_ready_o = w_grant1;

  // Scoreboard next state: the commit clear is applied first and the issue set
  // second, so a legal source-1 write to a non-pending register cannot erase a
  // freshly issued long-latency destination with the same index.
  always_comb begin
    w_issue_set    = issue_valid_i & issue_ready_o & issue_long_i & (issue_rd_i != 5'd0);
    w_commit_clear = r_rf_write & r_last_src1;
    w_busy_next    = r_busy;
    if (w_commit_clear) w_busy_next[r_rf_addr] = 1'b0;
    if (w_issue_set)    w_busy_next[issue_rd_i] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Starvation counter: counts consecutive denied source-1 requests, saturating.
  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      r_starve_cnt <= 3'd0;
    end else if (wb1_valid_i && !w_grant1) begin
      if (r_starve_cnt != c_starve_max) r_starve_cnt <= r_starve_cnt + 3'd1;
    end else begin
      r_starve_cnt <= 3'd0;
    end
  end

  // One-cycle write pipeline; address/data hold when nothing is granted.
  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      r_rf_write  <= 1'b0;
      r_rf_addr   <= 5'd0;
      r_rf_data   <= '0;
      r_last_src1 <= 1'b0;
    end else if (w_grant1) begin
      r_rf_write  <= (wb1_addr_i != 5'd0);
      r_rf_addr   <= wb1_addr_i;
      r_rf_data   <= wb1_data_i;
      r_last_src1 <= 1'b1;
    end else if (w_grant0) begin
      r_rf_write  <= (wb0_addr_i != 5'd0);
      r_rf_addr   <= wb0_addr_i;
      r_rf_data   <= wb0_data_i;
      r_last_src1 <= 1'b0;
    end else begin
      r_rf_write  <= 1'b0;
    end
  end

  assign rf_write_o = r_rf_write;
  assign rf_addr_o  = r_rf_addr;
  assign rf_data_o  = r_rf_data;
  assign busy_o     = r_busy;

`ifndef SYNTHESIS
  // A pending register must never be both committed and re-issued at one edge.
  always @(posedge clock_i) begin
    if (rst_n_i && w_issue_set && w_commit_clear && (r_rf_addr == issue_rd_i)) begin
      assert (!r_busy[issue_rd_i])
        else $error("scoreboard set/clear collision on x%0d", issue_rd_i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rf_writeback_scheduler                                    |
// | Description : Directed self-checking bench for rf_writeback_scheduler.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rf_writeback_scheduler;

  localparam int DATA_W = 32;

  logic              clock_i = 1'b0;
  logic              rst_n_i;
  logic              issue_valid_i;
  logic [4:0]        issue_rs1_i;
  logic [4:0]        issue_rs2_i;
  logic [4:0]        issue_rd_i;
  logic              issue_long_i;
  logic              issue_ready_o;
  logic              wb0_valid_i;
  logic [4:0]        wb0_addr_i;
  logic [DATA_W-1:0] wb0_data_i;
  logic              wb0_ready_o;
  logic              wb1_valid_i;
  logic [4:0]        wb1_addr_i;
  logic [DATA_W-1:0] wb1_data_i;
  logic              wb1_ready_o;
  logic              rf_write_o;
  logic [4:0]        rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic [31:0]       busy_o;

  int n_checks = 0;
  int n_errors = 0;

  rf_writeback_scheduler #(.DATA_W(DATA_W), .STARVE_LIMIT(3)) dut (
    .clock_i      (clock_i),
    .rst_n_i      (rst_n_i),
    .issue_valid_i(issue_valid_i),
    .issue_rs1_i  (issue_rs1_i),
    .issue_rs2_i  (issue_rs2_i),
    .issue_rd_i   (issue_rd_i),
    .issue_long_i (issue_long_i),
    .issue_ready_o(issue_ready_o),
    .wb0_valid_i  (wb0_valid_i),
    .wb0_addr_i   (wb0_addr_i),
    .wb0_data_i   (wb0_data_i),
    .wb0_ready_o  (wb0_ready_o),
    .wb1_valid_i  (wb1_valid_i),
    .wb1_addr_i   (wb1_addr_i),
    .wb1_data_i   (wb1_data_i),
    .wb1_ready_o  (wb1_ready_o),
    .rf_write_o   (rf_write_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .busy_o       (busy_o)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_rs1_i = 5'd0; issue_rs2_i = 5'd0;
    issue_rd_i = 5'd0; issue_long_i = 1'b0;
    wb0_valid_i = 1'b0; wb0_addr_i = 5'd0; wb0_data_i = '0;
    wb1_valid_i = 1'b0; wb1_addr_i = 5'd0; wb1_data_i = '0;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic lng);
    issue_valid_i = v; issue_rs1_i = rs1; issue_rs2_i = rs2;
    issue_rd_i = rd; issue_long_i = lng;
  endtask

  task automatic set_wb0(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb0_valid_i = v; wb0_addr_i = a; wb0_data_i = d;
  endtask

  task automatic set_wb1(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb1_valid_i = v; wb1_addr_i = a; wb1_data_i = d;
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    #1;
    // Reset state
    check("rst_busy",   busy_o,        32'h0);
    check("rst_write",  rf_write_o,    32'h0);
    check("rst_addr",   rf_addr_o,     32'h0);
    check("rst_data",   rf_data_o,     32'h0);
    check("rst_ready",  issue_ready_o, 32'h1);

    // Priority: both sources valid, source 0 wins by default
    set_wb0(1'b1, 5'd5, 32'hAAAA);
    set_wb1(1'b1, 5'd6, 32'hBBBB);
    #1;
    check("pri_rdy0", wb0_ready_o, 32'h1);
    check("pri_rdy1", wb1_ready_o, 32'h0);
    tick();
    check("pri_wr",   rf_write_o, 32'h1);
    check("pri_addr", rf_addr_o,  32'h5);
    check("pri_data", rf_data_o,  32'hAAAA);
    idle_inputs();
    tick();
    check("hold_wr",   rf_write_o, 32'h0);
    check("hold_addr", rf_addr_o,  32'h5);
    check("hold_data", rf_data_o,  32'hAAAA);

    // Starvation: source 1 denied three times, granted on the fourth cycle
    set_wb0(1'b1, 5'd1, 32'h11);
    set_wb1(1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("starve_deny1_%0d", i), wb1_ready_o, 32'h0);
      check($sformatf("starve_gnt0_%0d", i),  wb0_ready_o, 32'h1);
      tick();
    end
    #1;
    check("starve_gnt1", wb1_ready_o, 32'h1);
    check("starve_deny0", wb0_ready_o, 32'h0);
    tick();
    check("starve_addr", rf_addr_o, 32'h2);
    check("starve_data", rf_data_o, 32'h22);
    check("starve_wr",   rf_write_o, 32'h1);
    #1;
    check("starve_back0", wb0_ready_o, 32'h1);
    check("starve_back1", wb1_ready_o, 32'h0);
    idle_inputs();
    tick();

    // Scoreboard: long issue to x7, dependent stalls until x7 commits
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    check("sb_issue_rdy", issue_ready_o, 32'h1);
    tick();
    check("sb_busy7", busy_o, 32'h0000_0080);
    set_issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b0);
    #1;
    check("sb_dep_stall", issue_ready_o, 32'h0);
    issue_valid_i = 1'b0;
    #1;
    check("sb_stall_novalid", issue_ready_o, 32'h0);
    set_wb1(1'b1, 5'd7, 32'h77);
    #1;
    check("sb_wb1_gnt", wb1_ready_o, 32'h1);
    tick();
    set_wb1(1'b0, 5'd0, 32'h0);
    #1;
    check("sb_n1_wr",    rf_write_o,    32'h1);
    check("sb_n1_addr",  rf_addr_o,     32'h7);
    check("sb_n1_busy",  busy_o,        32'h0000_0080);
    check("sb_n1_stall", issue_ready_o, 32'h0);
    tick();
    check("sb_n2_busy",  busy_o,        32'h0);
    check("sb_n2_ready", issue_ready_o, 32'h1);
    idle_inputs();

    // x0 handling
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    issue_valid_i = 1'b0;
    check("x0_issue_busy", busy_o, 32'h0);
    set_wb1(1'b1, 5'd0, 32'h1234);
    #1;
    check("x0_wb1_rdy", wb1_ready_o, 32'h1);
    tick();
    idle_inputs();
    check("x0_wr",   rf_write_o, 32'h0);
    check("x0_addr", rf_addr_o,  32'h0);

    // WAW: x9 pending, non-long issue to x9 stalls; a wb0 write does not clear it
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    check("waw_busy9", busy_o, 32'h0000_0200);
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b0);
    set_wb0(1'b1, 5'd9, 32'h99);
    #1;
    check("waw_stall", issue_ready_o, 32'h0);
    tick();
    set_wb0(1'b0, 5'd0, 32'h0);
    check("waw_wb0_wr",   rf_write_o,    32'h1);
    check("waw_wb0_addr", rf_addr_o,     32'h9);
    check("waw_wb0_busy", busy_o,        32'h0000_0200);
    check("waw_wb0_stall", issue_ready_o, 32'h0);
    set_wb1(1'b1, 5'd9, 32'h909);
    tick();
    set_wb1(1'b0, 5'd0, 32'h0);
    #1;
    check("waw_n1_stall", issue_ready_o, 32'h0);
    tick();
    check("waw_n2_busy",  busy_o,        32'h0);
    check("waw_n2_ready", issue_ready_o, 32'h1);
    idle_inputs();

    // Reset mid-operation: busy x4, write in flight, starve counter at 2
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    issue_valid_i = 1'b0;
    set_wb0(1'b1, 5'd3, 32'h33);
    set_wb1(1'b1, 5'd4, 32'h44);
    tick();
    tick();
    check("mid_busy_pre",  busy_o,     32'h0000_0010);
    check("mid_write_pre", rf_write_o, 32'h1);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    check("mid_busy",  busy_o,     32'h0);
    check("mid_write", rf_write_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mid_deny1_%0d", i), wb1_ready_o, 32'h0);
      tick();
    end
    #1;
    check("mid_gnt1", wb1_ready_o, 32'h1);
    idle_inputs();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
Shares the single register-file write port between two writeback sources. Source 0 is the in-order pipeline (ALU/load). Source 1 is a multi-cycle unit (mul/div). The block also keeps a 32-entry scoreboard of registers awaiting a source-1 result and blocks issue of dependent instructions. It sits between the writeback stage, the long-latency unit and the register file's write_i/rd_addr_i/rd_data_i inputs.

Parameters:
DATA_W, 32, width of writeback data.
STARVE_LIMIT, 3, consecutive denied cycles after which source 1 takes priority (1..7).

Ports:
clock_i  in  1  single clock, all state updates on posedge.
rst_n_i  in  1  synchronous active-low reset.
issue_valid_i  in  1  decode presents an instruction.
issue_rs1_i  in  5  source register 1.
issue_rs2_i  in  5  source register 2.
issue_rd_i  in  5  destination register.
issue_long_i  in  1  destination will be written by source 1.
issue_ready_o  out  1  no hazard; instruction may issue this cycle.
wb0_valid_i  in  1  pipeline writeback request.
wb0_addr_i  in  5  pipeline destination.
wb0_data_i  in  DATA_W  pipeline data.
wb0_ready_o  out  1  pipeline request granted this cycle.
wb1_valid_i  in  1  long-unit writeback request.
wb1_addr_i  in  5  long-unit destination.
wb1_data_i  in  DATA_W  long-unit data.
wb1_ready_o  out  1  long-unit request granted this cycle.
rf_write_o  out  1  register-file write enable (registered).
rf_addr_o  out  5  register-file write address (registered).
rf_data_o  out  DATA_W  register-file write data (registered).
busy_o  out  32  scoreboard, bit n set = xn has a pending source-1 write.

Behaviour:
- Reset: when rst_n_i=0 at posedge, clear rf_write_o, rf_addr_o, rf_data_o, busy_o, the starve counter, and the last-grant-was-1 flag. Reset overrides all same-cycle events. busy_o[0] is always 0.
- Hazard check (combinational): issue_ready_o = !(busy[rs1] | busy[rs2] | busy[rd]). Index 0 never counts as busy. issue_ready_o does not depend on issue_valid_i.
- Issue: when issue_valid_i, issue_ready_o, issue_long_i are all 1 and rd!=0, set busy[rd] at the posedge.
- Arbitration (combinational grant):
  - Default: wb0 has priority. wb0_ready_o = wb0_valid_i; wb1_ready_o = wb1_valid_i & !wb0_valid_i.
  - When starve_cnt == STARVE_LIMIT, priority flips. wb1_ready_o = wb1_valid_i; wb0_ready_o = wb0_valid_i & !wb1_valid_i.
  - At most one ready is high per cycle.
- Starve counter (3-bit, saturating):
  - Increments when wb1_valid_i=1 and wb1_ready_o=0.
  - Clears to 0 when wb1 is granted or wb1_valid_i=0.
- Write pipeline, latency 1 cycle:
  - The granted request is registered into rf_addr_o/rf_data_o.
  - rf_write_o=1 only if a grant occurred and addr!=0. Writes to x0 are accepted (ready=1) but produce rf_write_o=0.
  - With no grant: rf_write_o=0; rf_addr_o/rf_data_o hold their previous values.
- Scoreboard clear:
  - Clear busy[rf_addr_o] at the posedge where rf_write_o=1 and the registered write came from source 1. This is the same edge at which the register file commits the data.
  - So a grant in cycle N gives a register-file update at the end of N+1. issue_ready_o can rise in N+2, when the combinational read returns the new value.
- Simultaneous set and clear of the same index is impossible, because issue is blocked while busy[rd]. The implementation asserts this in simulation.
- A source-1 write to a non-busy register is legal. It is written normally and the scoreboard is unchanged.
- A wb0 write to a busy register is written, but busy stays set.

Test Plan:
- Reset mid-operation: busy_o=32'h0000_0010 with rf_write_o=1, assert rst_n_i=0 for one edge -> busy_o=0, rf_write_o=0, starve_cnt=0 next cycle.
- Priority: wb0 (x5, 32'hAAAA) and wb1 (x6, 32'hBBBB) both valid -> wb0_ready_o=1, wb1_ready_o=0; next cycle rf_write_o=1, rf_addr_o=5, rf_data_o=32'hAAAA.
- Starvation: wb0 and wb1 both valid continuously, STARVE_LIMIT=3 -> wb1 denied 3 cycles, granted in the 4th cycle, then counter clears and wb0 regains priority.
- Scoreboard: issue long rd=x7 -> busy_o[7]=1; later issue with rs1=x7 -> issue_ready_o=0. wb1 write x7 granted at cycle N -> rf_write_o in N+1, busy_o[7]=0 and issue_ready_o=1 in N+2.
- x0 handling: issue long rd=x0 -> busy_o unchanged. wb1 to x0 -> wb1_ready_o=1, rf_write_o=0 next cycle.
- WAW block: busy_o[9]=1, issue non-long rd=x9 -> issue_ready_o=0 until the x9 source-1 write commits.
